// File: rtl/hp_reg3_fifo.sv
// rtl/hp_reg3_fifo.sv - Host-to-parasite two-entry byte buffer for Tube register 3
//
// The host writes bytes, the parasite reads them. The buffer holds one byte or
// two bytes, chosen by the host mode input.
//
// Ports:
//   p_clk            sole clock, rising edge
//   h_rst            synchronous active-high reset
//   h_selectData     host has register 3 data selected
//   h_wr_stb         host write strobe (qualified by h_selectData)
//   h_data           host write byte
//   h_two_byte       mode: 1 = 2-byte buffer, 0 = 1-byte buffer
//   h_nmi_enable     enables the parasite NMI request
//   h_clr_overrun    clears the sticky overrun flag
//   p_selectData     parasite has register 3 data selected
//   p_rd_stb         parasite read strobe (qualified by p_selectData)
//   p_data           head entry, combinational from storage
//   h_not_full       host may write
//   h_overrun        sticky: a host write was dropped
//   p_data_available parasite may read
//   p_nmi            NMI request to the parasite
module hp_reg3_fifo (
    input  logic       p_clk,
    input  logic       h_rst,
    input  logic       h_selectData,
    input  logic       h_wr_stb,
    input  logic [7:0] h_data,
    input  logic       h_two_byte,
    input  logic       h_nmi_enable,
    input  logic       h_clr_overrun,
    input  logic       p_selectData,
    input  logic       p_rd_stb,
    output logic [7:0] p_data,
    output logic       h_not_full,
    output logic       h_overrun,
    output logic       p_data_available,
    output logic       p_nmi
);

    logic [7:0] mem [0:1];
    logic       wr_ptr;
    logic       rd_ptr;
    logic [1:0] count;
    logic       mode_q;
    logic       overrun;

    logic [1:0] cap;
    logic       mode_change;
    logic       wr_req;
    logic       rd_req;
    logic       wr_accept;
    logic       wr_drop;
    logic       rd_accept;

    assign cap         = mode_q ? 2'd2 : 2'd1;
    assign mode_change = (h_two_byte != mode_q);
    assign wr_req      = h_selectData & h_wr_stb;
    assign rd_req      = p_selectData & p_rd_stb;

    // Writes are judged against the pre-cycle count, so a full buffer drops
    // the write even when a read frees a slot in the same cycle. A mode
    // change swallows both strobes.
    assign wr_accept = ~mode_change & wr_req & (count < cap);
    assign wr_drop   = ~mode_change & wr_req & ~(count < cap);
    assign rd_accept = ~mode_change & rd_req & (count != 2'd0);

    always_ff @(posedge p_clk) begin
        if (h_rst) begin
            mem[0]  <= 8'h00;
            mem[1]  <= 8'h00;
            wr_ptr  <= 1'b0;
            rd_ptr  <= 1'b0;
            count   <= 2'd0;
            mode_q  <= h_two_byte;
            overrun <= 1'b0;
        end else begin
            // Set has priority over clear when both occur in one cycle.
            if (wr_drop) begin
                overrun <= 1'b1;
            end else if (h_clr_overrun) begin
                overrun <= 1'b0;
            end

            if (mode_change) begin
                // Flush pointers and count; storage contents are kept.
                mode_q <= h_two_byte;
                wr_ptr <= 1'b0;
                rd_ptr <= 1'b0;
                count  <= 2'd0;
            end else begin
                if (wr_accept) begin
                    mem[wr_ptr] <= h_data;
                    wr_ptr      <= ~wr_ptr;
                end
                if (rd_accept) begin
                    rd_ptr <= ~rd_ptr;
                end
                case ({wr_accept, rd_accept})
                    2'b10:   count <= count + 2'd1;
                    2'b01:   count <= count - 2'd1;
                    default: count <= count;
                endcase
            end
        end
    end

    assign p_data           = mem[rd_ptr];
    assign h_not_full       = (count < cap);
    assign h_overrun        = overrun;
    // In 2-byte mode the parasite is only told once both bytes have arrived.
    assign p_data_available = mode_q ? (count == 2'd2) : (count != 2'd0);
    assign p_nmi            = h_nmi_enable & p_data_available;

endmodule

// File: tb/tb_hp_reg3_fifo.sv
// tb/tb_hp_reg3_fifo.sv - Directed self-checking bench for hp_reg3_fifo
module tb_hp_reg3_fifo;

    logic       p_clk = 1'b0;
    logic       h_rst = 1'b0;
    logic       h_selectData = 1'b0;
    logic       h_wr_stb = 1'b0;
    logic [7:0] h_data = 8'h00;
    logic       h_two_byte = 1'b0;
    logic       h_nmi_enable = 1'b0;
    logic       h_clr_overrun = 1'b0;
    logic       p_selectData = 1'b0;
    logic       p_rd_stb = 1'b0;
    logic [7:0] p_data;
    logic       h_not_full;
    logic       h_overrun;
    logic       p_data_available;
    logic       p_nmi;

    int n_cmp = 0;
    int n_bad = 0;

    hp_reg3_fifo dut (
        .p_clk            (p_clk),
        .h_rst            (h_rst),
        .h_selectData     (h_selectData),
        .h_wr_stb         (h_wr_stb),
        .h_data           (h_data),
        .h_two_byte       (h_two_byte),
        .h_nmi_enable     (h_nmi_enable),
        .h_clr_overrun    (h_clr_overrun),
        .p_selectData     (p_selectData),
        .p_rd_stb         (p_rd_stb),
        .p_data           (p_data),
        .h_not_full       (h_not_full),
        .h_overrun        (h_overrun),
        .p_data_available (p_data_available),
        .p_nmi            (p_nmi)
    );

    always #5 p_clk = ~p_clk;

    // One clock with the given strobes; outputs are settled on return.
    task automatic cyc(input logic wr, input logic rd, input logic [7:0] d);
        h_selectData = wr;
        h_wr_stb     = wr;
        h_data       = d;
        p_selectData = rd;
        p_rd_stb     = rd;
        @(posedge p_clk);
        #1;
        h_selectData = 1'b0;
        h_wr_stb     = 1'b0;
        p_selectData = 1'b0;
        p_rd_stb     = 1'b0;
    endtask

    task automatic test_reset;
        h_two_byte = 1'b0;
        h_rst = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);
        h_rst = 1'b0;
        n_cmp++; if (p_data !== 8'h00) begin n_bad++; $display("FAIL rst_p_data got %h want 00", p_data); end
        n_cmp++; if (h_not_full !== 1'b1) begin n_bad++; $display("FAIL rst_not_full got %b want 1", h_not_full); end
        n_cmp++; if (h_overrun !== 1'b0) begin n_bad++; $display("FAIL rst_overrun got %b want 0", h_overrun); end
        n_cmp++; if (p_data_available !== 1'b0) begin n_bad++; $display("FAIL rst_avail got %b want 0", p_data_available); end
        n_cmp++; if (p_nmi !== 1'b0) begin n_bad++; $display("FAIL rst_nmi got %b want 0", p_nmi); end
    endtask

    task automatic test_one_byte;
        cyc(1'b1, 1'b0, 8'h5A);
        n_cmp++; if (p_data_available !== 1'b1) begin n_bad++; $display("FAIL one_avail got %b want 1", p_data_available); end
        n_cmp++; if (p_data !== 8'h5A) begin n_bad++; $display("FAIL one_data got %h want 5a", p_data); end
        n_cmp++; if (h_not_full !== 1'b0) begin n_bad++; $display("FAIL one_full got %b want 0", h_not_full); end
        cyc(1'b0, 1'b1, 8'h00);
        n_cmp++; if (p_data_available !== 1'b0) begin n_bad++; $display("FAIL one_rd_avail got %b want 0", p_data_available); end
        n_cmp++; if (h_not_full !== 1'b1) begin n_bad++; $display("FAIL one_rd_nf got %b want 1", h_not_full); end
    endtask

    task automatic test_two_byte;
        h_two_byte = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);            // mode change flushes, pointers 0
        cyc(1'b1, 1'b0, 8'h11);
        n_cmp++; if (p_data_available !== 1'b0) begin n_bad++; $display("FAIL two_w1_avail got %b want 0", p_data_available); end
        n_cmp++; if (h_not_full !== 1'b1) begin n_bad++; $display("FAIL two_w1_nf got %b want 1", h_not_full); end
        cyc(1'b1, 1'b0, 8'h22);
        n_cmp++; if (p_data_available !== 1'b1) begin n_bad++; $display("FAIL two_w2_avail got %b want 1", p_data_available); end
        n_cmp++; if (h_not_full !== 1'b0) begin n_bad++; $display("FAIL two_w2_nf got %b want 0", h_not_full); end
        n_cmp++; if (p_data !== 8'h11) begin n_bad++; $display("FAIL two_w2_data got %h want 11", p_data); end
        cyc(1'b0, 1'b1, 8'h00);
        n_cmp++; if (p_data !== 8'h22) begin n_bad++; $display("FAIL two_r1_data got %h want 22", p_data); end
        n_cmp++; if (p_data_available !== 1'b0) begin n_bad++; $display("FAIL two_r1_avail got %b want 0", p_data_available); end
        n_cmp++; if (h_not_full !== 1'b1) begin n_bad++; $display("FAIL two_r1_nf got %b want 1", h_not_full); end
        cyc(1'b0, 1'b1, 8'h00);            // count 0, rd_ptr back to 0
        n_cmp++; if (p_data !== 8'h11) begin n_bad++; $display("FAIL two_r2_data got %h want 11", p_data); end
        n_cmp++; if (h_not_full !== 1'b1) begin n_bad++; $display("FAIL two_r2_nf got %b want 1", h_not_full); end
    endtask

    task automatic test_overrun;
        cyc(1'b1, 1'b0, 8'h01);
        cyc(1'b1, 1'b0, 8'h02);
        n_cmp++; if (h_overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_pre got %b want 0", h_overrun); end
        cyc(1'b1, 1'b0, 8'h03);
        n_cmp++; if (h_overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_set got %b want 1", h_overrun); end
        n_cmp++; if (p_data !== 8'h01) begin n_bad++; $display("FAIL ovr_head got %h want 01", p_data); end
        cyc(1'b0, 1'b1, 8'h00);
        n_cmp++; if (p_data !== 8'h02) begin n_bad++; $display("FAIL ovr_rd1 got %h want 02", p_data); end
        cyc(1'b0, 1'b1, 8'h00);
        n_cmp++; if (h_overrun !== 1'b1) begin n_bad++; $display("FAIL ovr_sticky got %b want 1", h_overrun); end
        h_clr_overrun = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);
        h_clr_overrun = 1'b0;
        n_cmp++; if (h_overrun !== 1'b0) begin n_bad++; $display("FAIL ovr_clr got %b want 0", h_overrun); end
    endtask

    task automatic test_simultaneous;
        // Full 1-byte buffer: write+read drops the write.
        h_two_byte = 1'b0;
        cyc(1'b0, 1'b0, 8'h00);            // flush
        cyc(1'b1, 1'b0, 8'hAA);
        n_cmp++; if (p_data !== 8'hAA) begin n_bad++; $display("FAIL sim_aa got %h want aa", p_data); end
        cyc(1'b1, 1'b1, 8'hBB);
        n_cmp++; if (h_overrun !== 1'b1) begin n_bad++; $display("FAIL sim_ovr got %b want 1", h_overrun); end
        n_cmp++; if (p_data_available !== 1'b0) begin n_bad++; $display("FAIL sim_avail got %b want 0", p_data_available); end
        n_cmp++; if (h_not_full !== 1'b1) begin n_bad++; $display("FAIL sim_nf got %b want 1", h_not_full); end
        // rd_ptr now 1; mem[1] still holds 02, not the dropped BB
        n_cmp++; if (p_data !== 8'h02) begin n_bad++; $display("FAIL sim_drop got %h want 02", p_data); end
        h_clr_overrun = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);
        h_clr_overrun = 1'b0;
        // Non-full 2-byte buffer holding one byte: write+read keeps count 1.
        h_two_byte = 1'b1;
        cyc(1'b0, 1'b0, 8'h00);            // flush
        cyc(1'b1, 1'b0, 8'hCC);
        cyc(1'b1, 1'b1, 8'hDD);
        n_cmp++; if (p_data !== 8'hDD) begin n_bad++; $display("FAIL sim2_head got %h want dd", p_data); end
        n_cmp++; if (p_data_available !== 1'b0) begin n_bad++; $display("FAIL sim2_avail got %b want 0", p_data_available); end
        n_cmp++; if (h_overrun !== 1'b0) begin n_bad++; $display("FAIL sim2_ovr got %b want 0", h_overrun); end
        cyc(1'b1, 1'b0, 8'hEE);            // count 1 -> 2 proves count was 1
        n_cmp++; if (p_data_available !== 1'b1) begin n_bad++; $display("FAIL sim2_cnt got %b want 1", p_data_available); end
        n_cmp++; if (p_data !== 8'hDD) begin n_bad++; $display("FAIL sim2_keep got %h want dd", p_data); end
    endtask

    task automatic test_mode_flush;
        cyc(1'b0, 1'b1, 8'h00);            // one byte held: EE at mem[0]
        n_cmp++; if (p_data !== 8'hEE) begin n_bad++; $display("FAIL mf_head got %h want ee", p_data); end
        h_two_byte = 1'b0;
        cyc(1'b1, 1'b0, 8'h77);
        n_cmp++; if (h_not_full !== 1'b1) begin n_bad++; $display("FAIL mf_nf got %b want 1", h_not_full); end
        n_cmp++; if (p_data_available !== 1'b0) begin n_bad++; $display("FAIL mf_avail got %b want 0", p_data_available); end
        n_cmp++; if (h_overrun !== 1'b0) begin n_bad++; $display("FAIL mf_ovr got %b want 0", h_overrun); end
        n_cmp++; if (p_data !== 8'hEE) begin n_bad++; $display("FAIL mf_ignored got %h want ee", p_data); end
    endtask

    task automatic test_reset_nmi;
        h_nmi_enable = 1'b1;
        cyc(1'b1, 1'b0, 8'h33);
        n_cmp++; if (p_nmi !== 1'b1) begin n_bad++; $display("FAIL nmi_on got %b want 1", p_nmi); end
        n_cmp++; if (p_data !== 8'h33) begin n_bad++; $display("FAIL nmi_data got %h want 33", p_data); end
        h_nmi_enable = 1'b0;
        #1;
        n_cmp++; if (p_nmi !== 1'b0) begin n_bad++; $display("FAIL nmi_gate got %b want 0", p_nmi); end
        h_nmi_enable = 1'b1;
        // Reset with a read strobe, sampling two-byte mode during reset.
        h_two_byte = 1'b1;
        h_rst = 1'b1;
        cyc(1'b0, 1'b1, 8'h00);
        h_rst = 1'b0;
        n_cmp++; if (p_data !== 8'h00) begin n_bad++; $display("FAIL rr_data got %h want 00", p_data); end
        n_cmp++; if (h_not_full !== 1'b1) begin n_bad++; $display("FAIL rr_nf got %b want 1", h_not_full); end
        n_cmp++; if (h_overrun !== 1'b0) begin n_bad++; $display("FAIL rr_ovr got %b want 0", h_overrun); end
        n_cmp++; if (p_data_available !== 1'b0) begin n_bad++; $display("FAIL rr_avail got %b want 0", p_data_available); end
        n_cmp++; if (p_nmi !== 1'b0) begin n_bad++; $display("FAIL rr_nmi got %b want 0", p_nmi); end
        // mode_q came from reset, so no flush: first write lands, one byte is not enough.
        cyc(1'b1, 1'b0, 8'h44);
        n_cmp++; if (p_data_available !== 1'b0) begin n_bad++; $display("FAIL rr_mode_avail got %b want 0", p_data_available); end
        n_cmp++; if (p_data !== 8'h44) begin n_bad++; $display("FAIL rr_mode_data got %h want 44", p_data); end
        cyc(1'b1, 1'b0, 8'h45);
        n_cmp++; if (p_nmi !== 1'b1) begin n_bad++; $display("FAIL rr_mode_nmi got %b want 1", p_nmi); end
    endtask

    initial begin
        test_reset;
        test_one_byte;
        test_two_byte;
        test_overrun;
        test_simultaneous;
        test_mode_flush;
        test_reset_nmi;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
